// File: rtl/sdm_bitstream_tx.sv
// First-order delta-sigma bitstream transmitter.
// Accepts signed DATA_W-bit samples over valid/ready, holds one sample in a
// look-ahead buffer, and emits OSR modulator bits per sample, one bit every
// DIV clocks. The accumulator is DATA_W+2 bits wide, which bounds |acc| to
// 2*FS for every legal input, so the loop needs no saturation.
module sdm_bitstream_tx #(
  parameter int DATA_W = 12,
  parameter int OSR    = 32,
  parameter int DIV    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic              o_bit_out,
  output logic              o_bit_valid,
  output logic              o_sample_strobe,
  output logic              o_underrun
);

  localparam int ACC_W = DATA_W + 2;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSR_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);
  // +FS and -FS expressed at accumulator width
  localparam logic signed [ACC_W-1:0] FS_POS = {2'b00, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] FS_NEG = -FS_POS;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [DATA_W-1:0]       r_nxt;
  logic                    r_nxt_full;
  logic [DATA_W-1:0]       r_cur;
  logic signed [ACC_W-1:0] r_acc;
  logic [DIV_W-1:0]        r_div_cnt;
  logic [OSR_W-1:0]        r_osr_cnt;
  logic                    r_bit_out;
  logic                    r_bit_valid;
  logic                    r_strobe;
  logic                    r_underrun;

  logic                    w_write;
  logic                    w_run;
  logic                    w_tick;
  logic                    w_boundary;
  logic                    w_load;
  logic                    w_under_set;
  logic signed [ACC_W-1:0] w_cur_ext;
  logic signed [ACC_W-1:0] w_fb;
  logic signed [ACC_W-1:0] w_v;

  // Ready depends only on buffer occupancy, never on s_valid.
  assign w_write   = i_s_valid && !r_nxt_full;
  assign w_cur_ext = {{2{r_cur[DATA_W-1]}}, r_cur};
  assign w_fb      = r_bit_out ? FS_POS : FS_NEG;
  assign w_v       = r_acc + w_cur_ext - w_fb;

  // Next-state and control decode; leaving RUN takes priority over a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_tick      = 1'b0;
    w_boundary  = 1'b0;
    w_load      = 1'b0;
    w_under_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && r_nxt_full) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_enable) begin
          w_state_nxt = ST_RUN;
          w_run       = 1'b1;
          w_tick      = (r_div_cnt == DIV_LAST);
          w_boundary  = w_tick && (r_osr_cnt == OSR_LAST);
          w_load      = w_boundary && r_nxt_full;
          w_under_set = w_boundary && !r_nxt_full;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Look-ahead buffer and current sample; a load empties the buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nxt      <= {DATA_W{1'b0}};
      r_nxt_full <= 1'b0;
      r_cur      <= {DATA_W{1'b0}};
    end else begin
      if (w_write) begin
        r_nxt      <= i_s_data;
        r_nxt_full <= 1'b1;
      end else if (w_load) begin
        r_nxt_full <= 1'b0;
      end
      if (w_load) begin
        r_cur <= r_nxt;
      end
    end
  end

  // Bit-tick divider, bit counter and modulator loop; cleared outside RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_osr_cnt <= {OSR_W{1'b0}};
      r_acc     <= {ACC_W{1'b0}};
      r_bit_out <= 1'b0;
    end else if (w_run) begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? {DIV_W{1'b0}} : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_acc     <= w_v;
        r_bit_out <= !w_v[ACC_W-1];
        r_osr_cnt <= (r_osr_cnt == OSR_LAST) ? {OSR_W{1'b0}} : r_osr_cnt + OSR_W'(1);
      end
    end else begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_osr_cnt <= {OSR_W{1'b0}};
      r_acc     <= {ACC_W{1'b0}};
      r_bit_out <= 1'b0;
    end
  end

  // Registered status pulses and the sticky underrun flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_valid <= 1'b0;
      r_strobe    <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_bit_valid <= w_tick;
      r_strobe    <= w_load;
      if (w_under_set) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign o_s_ready       = !r_nxt_full;
  assign o_bit_out       = r_bit_out;
  assign o_bit_valid     = r_bit_valid;
  assign o_sample_strobe = r_strobe;
  assign o_underrun      = r_underrun;

endmodule

// File: tb/tb_sdm_bitstream_tx.sv
// Directed bench for sdm_bitstream_tx with a sample scoreboard and a
// cycle-level reference of the modulator.
module tb_sdm_bitstream_tx;

  localparam int DATA_W = 12;
  localparam int OSR    = 32;
  localparam int DIV    = 4;
  localparam int FS     = 2048;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_enable;
  logic [DATA_W-1:0] i_s_data;
  logic              i_s_valid;
  logic              o_s_ready;
  logic              o_bit_out;
  logic              o_bit_valid;
  logic              o_sample_strobe;
  logic              o_underrun;

  sdm_bitstream_tx #(.DATA_W(DATA_W), .OSR(OSR), .DIV(DIV)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_enable        (i_enable),
    .i_s_data        (i_s_data),
    .i_s_valid       (i_s_valid),
    .o_s_ready       (o_s_ready),
    .o_bit_out       (o_bit_out),
    .o_bit_valid     (o_bit_valid),
    .o_sample_strobe (o_sample_strobe),
    .o_underrun      (o_underrun)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic started = 1'b0;

  int   exp_q[$];            // scoreboard: accepted samples not yet current
  int   m_acc = 0;
  int   m_cur = 0;
  int   m_div = 0;
  int   m_osr = 0;
  logic m_bit = 1'b0;
  logic m_run = 1'b0;
  logic m_under = 1'b0;

  int   wr_cyc = 0;
  int   load_cyc = 0;
  int   first_bit_cyc = 0;
  int   last_strobe = 0;
  int   prev_strobe = 0;
  int   d_bits = 0;
  int   w_ones = 0;
  int   w_bits = 0;
  int   last_win = -1;
  int   bit_log[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: record an accepted write, advance the reference, compare outputs.
  task automatic step();
    int   qn;
    int   fb;
    int   v;
    logic wr;
    logic rst_e;
    logic en_e;
    logic exp_bv;
    logic exp_st;
    qn = exp_q.size();
    if (started) chk1("s_ready", o_s_ready, (qn == 0));
    wr    = i_s_valid && o_s_ready;
    rst_e = i_rst;
    en_e  = i_enable;
    if (wr && !rst_e) begin
      exp_q.push_back(int'($signed(i_s_data)));
      wr_cyc = cyc + 1;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    started = 1'b1;
    exp_bv = 1'b0;
    exp_st = 1'b0;
    if (rst_e) begin
      exp_q.delete();
      m_run = 1'b0; m_acc = 0; m_bit = 1'b0; m_under = 1'b0; m_div = 0; m_osr = 0;
    end else if (!en_e) begin
      m_run = 1'b0; m_acc = 0; m_bit = 1'b0; m_div = 0; m_osr = 0;
    end else if (!m_run) begin
      if (qn > 0) begin
        m_cur = exp_q.pop_front();
        m_run = 1'b1; exp_st = 1'b1; m_div = 0; m_osr = 0;
        load_cyc = cyc;
        bit_log.delete();
        w_ones = 0; w_bits = 0; last_win = -1;
      end
    end else if (m_div == DIV - 1) begin
      m_div  = 0;
      exp_bv = 1'b1;
      fb     = m_bit ? FS : -FS;
      v      = m_acc + m_cur - fb;
      m_acc  = v;
      m_bit  = (v >= 0);
      if (m_osr == OSR - 1) begin
        m_osr = 0;
        if (qn > 0) begin
          m_cur  = exp_q.pop_front();
          exp_st = 1'b1;
        end else begin
          m_under = 1'b1;
        end
      end else begin
        m_osr++;
      end
    end else begin
      m_div++;
    end
    if (o_bit_valid) begin
      if (bit_log.size() == 0) first_bit_cyc = cyc;
      bit_log.push_back(int'(o_bit_out));
      d_bits++;
      w_ones += int'(o_bit_out);
      w_bits++;
      if (w_bits == OSR) begin
        last_win = w_ones; w_ones = 0; w_bits = 0;
      end
    end
    if (o_sample_strobe) begin
      prev_strobe = last_strobe;
      last_strobe = cyc;
    end
    chk1("bit_valid", o_bit_valid, exp_bv);
    chk1("sample_strobe", o_sample_strobe, exp_st);
    chk1("bit_out", o_bit_out, m_bit);
    chk1("underrun", o_underrun, m_under);
    if (exp_bv) begin
      chki("acc", int'(dut.r_acc), m_acc);
      chk1("acc_range", (int'(dut.r_acc) <= 2 * FS) && (int'(dut.r_acc) >= -2 * FS), 1'b1);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic push(input int val);
    int   b;
    logic acc;
    b = 0;
    acc = 1'b0;
    i_s_valid = 1'b1;
    i_s_data  = DATA_W'(val);
    while (!acc && b < 400) begin
      acc = o_s_ready;
      step();
      b++;
    end
    i_s_valid = 1'b0;
    chk1("push_accepted", acc, 1'b1);
  endtask

  // Advance until n more bits have been emitted (bounded).
  task automatic wait_bits(input int n);
    int b;
    int tgt;
    b = 0;
    tgt = d_bits + n;
    while (d_bits < tgt && b < n * DIV * 2 + 300) begin
      step();
      b++;
    end
    chk1("wait_bits_in_time", (d_bits >= tgt), 1'b1);
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b0; i_s_valid = 1'b0; i_s_data = '0;

    // 1: reset values
    run(3);
    chk1("rst_s_ready", o_s_ready, 1'b1);
    chk1("rst_bit_valid", o_bit_valid, 1'b0);
    chk1("rst_underrun", o_underrun, 1'b0);
    i_rst = 1'b0;

    // 2: single zero sample
    i_enable = 1'b1;
    push(0);
    step();
    chki("t2_strobe_latency", last_strobe - wr_cyc, 1);
    wait_bits(32);
    chki("t2_first_bit_latency", first_bit_cyc - load_cyc, DIV);
    chki("t2_bit0", bit_log[0], 1);
    chki("t2_bit1", bit_log[1], 1);
    chki("t2_bit2", bit_log[2], 0);
    chki("t2_bit3", bit_log[3], 1);
    chki("t2_bit4", bit_log[4], 0);
    chki("t2_bit5", bit_log[5], 1);
    chk1("t2_underrun_at_32", o_underrun, 1'b1);

    // 3: back-to-back +1024
    i_rst = 1'b1; step(); i_rst = 1'b0;
    for (int k = 0; k < 6; k++) push(1024);
    chki("t3_strobe_period", last_strobe - prev_strobe, OSR * DIV);
    chki("t3_window_ones", last_win, 24);
    chk1("t3_no_underrun", o_underrun, 1'b0);

    // 4: full-scale negative then near full-scale positive
    i_rst = 1'b1; step(); i_rst = 1'b0;
    for (int k = 0; k < 4; k++) push(-2048);
    chki("t4_zero_window", last_win, 0);
    for (int k = 0; k < 3; k++) push(2047);
    chk1("t4_dense_window_a", (last_win >= 31), 1'b1);
    wait_bits(32);
    chk1("t4_dense_window_b", (last_win >= 31), 1'b1);
    chk1("t4_no_underrun", o_underrun, 1'b0);

    // 5: single -512 then starve
    i_rst = 1'b1; step(); i_rst = 1'b0;
    push(-512);
    wait_bits(32);
    chki("t5_boundary_time", cyc - load_cyc, OSR * DIV);
    chk1("t5_underrun", o_underrun, 1'b1);
    wait_bits(16);
    push(1024);
    chk1("t5_underrun_sticky", o_underrun, 1'b1);
    wait_bits(16);
    chki("t5_window_ones", last_win, 12);
    chki("t5_late_load_time", last_strobe - load_cyc, 2 * OSR * DIV);

    // 6: enable drop, re-enable from buffered sample, reset mid-run
    push(0);
    run(10);
    i_enable = 1'b0;
    step();
    chk1("t6_off_bit_out", o_bit_out, 1'b0);
    chk1("t6_off_bit_valid", o_bit_valid, 1'b0);
    chki("t6_off_acc", int'(dut.r_acc), 0);
    run(5);
    i_enable = 1'b1;
    step();
    chk1("t6_reload_strobe", o_sample_strobe, 1'b1);
    wait_bits(1);
    chki("t6_restart_latency", first_bit_cyc - load_cyc, DIV);
    chki("t6_restart_bit0", bit_log[0], 1);
    push(-100);
    run(10);
    chk1("t6_pre_rst_ready", o_s_ready, 1'b0);
    chk1("t6_pre_rst_underrun", o_underrun, 1'b1);
    i_rst = 1'b1;
    step();
    chk1("t6_rst_ready", o_s_ready, 1'b1);
    chk1("t6_rst_underrun", o_underrun, 1'b0);
    i_rst = 1'b0;
    run(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
